// File: rtl/stream_packer_if.sv
// Handshake bundle between a beat producer, the packer and a word consumer.
// The master side drives the narrow beat stream and consumes packed words;
// the slave side is the packer itself.
interface stream_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 16
);
  localparam int OUT_W = IN_W * RATIO;

  // Narrow input stream
  logic              pixel_tvalid;
  logic              pixel_tready;
  logic [IN_W-1:0]   pixel_tdata;
  logic              pixel_tlast;
  logic              flush_in;

  // Packed output stream
  logic              chunk_tvalid;
  logic              chunk_tready;
  logic [OUT_W-1:0]  chunk_tdata;
  logic [RATIO-1:0]  chunk_tkeep;
  logic              chunk_tlast;

  modport master (
    output pixel_tvalid, pixel_tdata, pixel_tlast, flush_in, chunk_tready,
    input  pixel_tready, chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast
  );

  modport slave (
    input  pixel_tvalid, pixel_tdata, pixel_tlast, flush_in, chunk_tready,
    output pixel_tready, chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast
  );
endinterface

// File: rtl/stream_packer.sv
// Packs RATIO consecutive IN_W-bit beats into one OUT_W-bit word, first beat
// in the least significant lane. A word closes when it is full, on tlast
// (when FLUSH_ON_LAST is set) or on a flush request; partial words carry a
// tkeep mask of the filled lanes. A single output register decouples the
// two sides, so input throughput is one beat per clock while the consumer
// keeps up.
module stream_packer #(
  parameter int IN_W          = 8,
  parameter int RATIO         = 16,
  parameter bit FLUSH_ON_LAST = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  stream_packer_if.slave  bus,
  output logic [31:0]     words_out
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  // Accumulator: lanes 0..count_q-1 hold beats of the word in progress
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] acc_q;
  logic             acc_last_q;
  logic             flush_pend_q;

  // Output register
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [RATIO-1:0] out_keep_q;
  logic             out_last_q;

  // Combinational handshake and merge results
  logic             out_free;
  logic             beat_acc;
  logic             word_acc;
  logic             flush_req;
  logic             close_beat;
  logic             close_flush;
  logic             close_word;
  logic [CNT_W:0]   fill;
  logic [OUT_W-1:0] acc_merged;
  logic [RATIO-1:0] keep_merged;
  logic             last_merged;

  assign bus.pixel_tready = out_free;
  assign bus.chunk_tvalid = out_valid_q;
  assign bus.chunk_tdata  = out_data_q;
  assign bus.chunk_tkeep  = out_keep_q;
  assign bus.chunk_tlast  = out_last_q;

  // Decide acceptance and closing, and form the word as it would look with this cycle's beat.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is inferred.
    acc_merged  = acc_q;
    keep_merged = '0;
    last_merged = acc_last_q;

    // The output register can take a new word when empty or being drained now.
    out_free  = !out_valid_q || bus.chunk_tready;
    beat_acc  = bus.pixel_tvalid && out_free;
    word_acc  = out_valid_q && bus.chunk_tready;
    flush_req = bus.flush_in || flush_pend_q;

    // A beat closes the word when it fills the last lane, carries tlast in
    // flush-on-last mode, or arrives together with a flush request.
    close_beat  = beat_acc && ((count_q == LAST_LANE) ||
                               (FLUSH_ON_LAST && bus.pixel_tlast) ||
                               flush_req);
    // A flush without a beat only closes a non-empty word, and only when the
    // output register can take it; otherwise the request stays pending.
    close_flush = !beat_acc && flush_req && (count_q != '0) && out_free;
    close_word  = close_beat || close_flush;

    fill = {1'b0, count_q} + (CNT_W + 1)'(beat_acc);

    if (beat_acc && bus.pixel_tlast) begin
      last_merged = 1'b1;
    end

    for (int k = 0; k < RATIO; k++) begin
      if (beat_acc && (count_q == CNT_W'(k))) begin
        acc_merged[k*IN_W +: IN_W] = bus.pixel_tdata;
      end
      keep_merged[k] = (k < int'(fill));
    end
  end

  // Output register: load on close, hold while stalled, empty after acceptance.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (close_word) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_merged;
      out_keep_q  <= keep_merged;
      out_last_q  <= last_merged;
    end else if (word_acc) begin
      out_valid_q <= 1'b0;
    end
  end

  // Accumulator: collect beats, restart empty after each close.
  always_ff @(posedge clk_in) begin
    // NOTE: the accumulator data is cleared on reset and on close so unfilled lanes of a partial word read as zero.
    if (rst_in) begin
      acc_q        <= '0;
      acc_last_q   <= 1'b0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (close_word) begin
        acc_q      <= '0;
        acc_last_q <= 1'b0;
        count_q    <= '0;
      end else if (beat_acc) begin
        acc_q      <= acc_merged;
        acc_last_q <= last_merged;
        count_q    <= count_q + CNT_W'(1);
      end
      flush_pend_q <= flush_req && !close_word && (count_q != '0);
    end
  end

  // Count words taken by the consumer; wraps naturally at 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      words_out <= '0;
    end else if (word_acc) begin
      words_out <= words_out + 32'd1;
    end
  end
endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer at IN_W=8, RATIO=4, FLUSH_ON_LAST=1. A queue-based
// reference model is compared against the outputs every cycle, a stream
// scoreboard checks accepted words against the accepted beats, and directed
// sequences pin hand-computed words.
module tb_stream_packer;
  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  typedef struct {
    logic [IN_W-1:0] d;
    logic            l;
  } beat_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] words_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  stream_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

  stream_packer #(
    .IN_W(IN_W), .RATIO(RATIO), .FLUSH_ON_LAST(1'b1)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .bus      (bus.slave),
    .words_out(words_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t            part[$];   // beats of the word in progress
  beat_t            in_q[$];   // accepted beats not yet taken downstream
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_data  = '0;
  logic [RATIO-1:0] m_keep  = '0;
  logic             m_last  = 1'b0;
  logic             m_pend  = 1'b0;
  logic [31:0]      m_words = '0;

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial begin
    logic  ready, beat, wacc, fr, cl, ok, lastor;
    beat_t b;
    int    sz;
    @(posedge clk_in);
    forever begin
      @(negedge clk_in);
      ready = !m_valid || bus.chunk_tready;
      check("pixel_tready", bus.pixel_tready, ready);
      check("chunk_tvalid", bus.chunk_tvalid, m_valid);
      check("words_out", words_out, m_words);
      if (m_valid) begin
        check("chunk_tdata", bus.chunk_tdata, m_data);
        check("chunk_tkeep", bus.chunk_tkeep, m_keep);
        check("chunk_tlast", bus.chunk_tlast, m_last);
      end
      if (rst_in) begin
        part.delete();
        in_q.delete();
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_words = '0;
      end else begin
        beat = bus.pixel_tvalid && ready;
        wacc = m_valid && bus.chunk_tready;
        fr   = bus.flush_in || m_pend;
        if (wacc) begin
          m_words++;
          ok     = 1'b1;
          lastor = 1'b0;
          for (int k = 0; k < RATIO; k++) begin
            if (bus.chunk_tkeep[k]) begin
              if (in_q.size() == 0) ok = 1'b0;
              else begin
                b = in_q.pop_front();
                if (b.d !== bus.chunk_tdata[k*IN_W +: IN_W]) ok = 1'b0;
                lastor |= b.l;
              end
            end
          end
          if (lastor !== bus.chunk_tlast) ok = 1'b0;
          check("stream_order", ok, 1'b1);
        end
        if (beat) begin
          b.d = bus.pixel_tdata;
          b.l = bus.pixel_tlast;
          part.push_back(b);
          in_q.push_back(b);
        end
        sz = part.size();
        cl = (beat && (sz == RATIO || bus.pixel_tlast || fr)) ||
             (!beat && fr && sz > 0 && ready);
        if (cl) begin
          m_data = '0;
          m_last = 1'b0;
          for (int k = 0; k < sz; k++) begin
            m_data[k*IN_W +: IN_W] = part[k].d;
            m_last |= part[k].l;
          end
          m_keep  = RATIO'((1 << sz) - 1);
          m_valid = 1'b1;
          m_pend  = 1'b0;
          part.delete();
        end else begin
          if (wacc) m_valid = 1'b0;
          m_pend = fr && (sz > 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Offer one beat until accepted (bounded); tvalid stays high afterwards.
  task automatic send(input logic [IN_W-1:0] d, input logic l, input logic f);
    int   n = 0;
    logic acc;
    bus.pixel_tvalid = 1'b1;
    bus.pixel_tdata  = d;
    bus.pixel_tlast  = l;
    bus.flush_in     = f;
    do begin
      #2;
      acc = bus.pixel_tready;
      @(posedge clk_in);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", acc, 1'b1);
    bus.flush_in    = 1'b0;
    bus.pixel_tlast = 1'b0;
  endtask

  task automatic idle();
    bus.pixel_tvalid = 1'b0;
    bus.flush_in     = 1'b0;
    bus.pixel_tlast  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequences ----------------
  initial begin
    int idx;
    int n;
    logic acc;
    bus.pixel_tvalid = 1'b0;
    bus.pixel_tdata  = '0;
    bus.pixel_tlast  = 1'b0;
    bus.flush_in     = 1'b0;
    bus.chunk_tready = 1'b1;

    // Reset state
    repeat (3) tick();
    #2;
    check("rst_tvalid", bus.chunk_tvalid, 1'b0);
    check("rst_tdata", bus.chunk_tdata, 32'h0);
    check("rst_tkeep", bus.chunk_tkeep, 4'h0);
    check("rst_tlast", bus.chunk_tlast, 1'b0);
    check("rst_words", words_out, 32'd0);
    rst_in = 1'b0;
    tick();
    #2;
    check("rel_tready", bus.pixel_tready, 1'b1);
    tick();

    // Full word on consecutive clocks
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    idle();
    #2;
    check("full_valid", bus.chunk_tvalid, 1'b1);
    check("full_data", bus.chunk_tdata, 32'h44332211);
    check("full_keep", bus.chunk_tkeep, 4'b1111);
    check("full_last", bus.chunk_tlast, 1'b0);
    tick();
    #2;
    check("full_words", words_out, 32'd1);
    check("full_drop", bus.chunk_tvalid, 1'b0);
    tick();

    // tlast closes a partial word; next beat restarts at lane 0
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b1, 1'b0);
    idle();
    #2;
    check("last_data", bus.chunk_tdata, 32'h0000BBAA);
    check("last_keep", bus.chunk_tkeep, 4'b0011);
    check("last_last", bus.chunk_tlast, 1'b1);
    tick();
    send(8'h5A, 1'b1, 1'b0);
    idle();
    #2;
    check("lane0_data", bus.chunk_tdata, 32'h0000005A);
    check("lane0_keep", bus.chunk_tkeep, 4'b0001);
    tick();
    #2;
    check("last_words", words_out, 32'd3);
    tick();

    // Flush without a beat emits the partial word; flush when empty is a no-op
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    idle();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    #2;
    check("flush_valid", bus.chunk_tvalid, 1'b1);
    check("flush_data", bus.chunk_tdata, 32'h00030201);
    check("flush_keep", bus.chunk_tkeep, 4'b0111);
    tick();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    #2;
    check("empty_flush_valid", bus.chunk_tvalid, 1'b0);
    tick();
    #2;
    check("empty_flush_valid2", bus.chunk_tvalid, 1'b0);
    check("flush_words", words_out, 32'd4);
    tick();

    // Flush together with a beat includes that beat
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b1);
    idle();
    #2;
    check("flushbeat_data", bus.chunk_tdata, 32'h00002010);
    check("flushbeat_keep", bus.chunk_tkeep, 4'b0011);
    tick();

    // Backpressure: 12 beats offered while the consumer stalls for 10 cycles
    bus.chunk_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.pixel_tvalid = 1'b1;
      bus.pixel_tdata  = 8'h90 + 8'(idx);
      #2;
      acc = bus.pixel_tready;
      tick();
      if (acc) idx++;
    end
    #2;
    check("stall_accepted", idx, 4);
    check("stall_tready", bus.pixel_tready, 1'b0);
    check("stall_data", bus.chunk_tdata, 32'h93929190);
    bus.chunk_tready = 1'b1;
    n = 0;
    while (idx < 12 && n < 100) begin
      bus.pixel_tvalid = 1'b1;
      bus.pixel_tdata  = 8'h90 + 8'(idx);
      #2;
      acc = bus.pixel_tready;
      tick();
      if (acc) idx++;
      n++;
    end
    check("stall_all_beats", idx, 12);
    idle();
    tick();
    #2;
    check("stall_words", words_out, 32'd8);
    tick();

    // Reset mid-word discards the partial beats
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    idle();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    #2;
    check("rst_mid_valid", bus.chunk_tvalid, 1'b0);
    check("rst_mid_words", words_out, 32'd0);
    tick();

    // Reset with a stalled word discards it
    bus.chunk_tready = 1'b0;
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b0);
    send(8'hA4, 1'b0, 1'b0);
    idle();
    #2;
    check("stalled_valid", bus.chunk_tvalid, 1'b1);
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    #2;
    check("rst_stall_valid", bus.chunk_tvalid, 1'b0);
    check("rst_stall_data", bus.chunk_tdata, 32'h0);
    check("rst_stall_words", words_out, 32'd0);
    bus.chunk_tready = 1'b1;
    tick();
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'hC4, 1'b0, 1'b0);
    idle();
    #2;
    check("clean_data", bus.chunk_tdata, 32'hC4C3C2C1);
    check("clean_keep", bus.chunk_tkeep, 4'b1111);
    tick();
    #2;
    check("clean_words", words_out, 32'd1);
    tick();

    // Random traffic, flushes and backpressure
    for (int i = 0; i < 4000; i++) begin
      bus.pixel_tvalid = ($urandom_range(0, 3) != 0);
      bus.pixel_tdata  = 8'($urandom);
      bus.pixel_tlast  = ($urandom_range(0, 7) == 0);
      bus.flush_in     = ($urandom_range(0, 15) == 0);
      bus.chunk_tready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    bus.chunk_tready = 1'b1;
    bus.flush_in     = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    repeat (3) tick();
    #2;
    check("drain_valid", bus.chunk_tvalid, 1'b0);
    check("drain_stream_empty", in_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter IN_W, default 8, input beat width in bits (>=1).
REQ-002 Parameter RATIO, default 16, input beats per output word (>=2); OUT_W = IN_W*RATIO.
REQ-003 Parameter FLUSH_ON_LAST, default 1; 1 = input tlast closes the word in progress, 0 = tlast only ORed into chunk_tlast.
REQ-004 clk_in  input  1  single clock; all logic on rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 pixel_tvalid  input  1  input beat valid.
REQ-007 pixel_tready  output  1  input beat accepted when high with tvalid.
REQ-008 pixel_tdata  input  IN_W  input beat payload.
REQ-009 pixel_tlast  input  1  end-of-frame marker on input beat.
REQ-010 flush_in  input  1  single-cycle request to emit a partial word.
REQ-011 chunk_tvalid  output  1  output word valid.
REQ-012 chunk_tready  input  1  downstream ready.
REQ-013 chunk_tdata  output  OUT_W  packed word; beat k of the word in bits [k*IN_W +: IN_W].
REQ-014 chunk_tkeep  output  RATIO  bit k = lane k holds a real beat.
REQ-015 chunk_tlast  output  1  word contains a tlast beat.
REQ-016 words_out  output  32  count of output words accepted downstream, wraps modulo 2^32.

Function
REQ-017 Beat accepted iff pixel_tvalid && pixel_tready; word accepted iff chunk_tvalid && chunk_tready.
REQ-018 pixel_tready = !chunk_tvalid || chunk_tready; combinational; independent of pixel_tdata and pixel_tlast.
REQ-019 Accumulator holds lanes 0..count-1; each accepted beat is written to lane count; count increments; first beat lands in LSB lane.
REQ-020 Word closes on an accepted beat when count == RATIO-1, or when pixel_tlast is high and FLUSH_ON_LAST = 1.
REQ-021 On close, the cycle after the closing beat: chunk_tvalid = 1; chunk_tdata = accumulator including closing beat; unfilled lanes = 0; chunk_tkeep = lanes filled; chunk_tlast = OR of tlast over the word's beats; count = 0.
REQ-022 Latency: closing beat accepted in cycle N -> chunk_tvalid high in cycle N+1.
REQ-023 chunk_tdata, chunk_tkeep and chunk_tlast hold stable while chunk_tvalid && !chunk_tready.
REQ-024 chunk_tvalid drops the cycle after word acceptance unless a new word closes in the same cycle, in which case it stays high with the new contents.
REQ-025 Sustained throughput is 1 beat/clk when chunk_tready stays high; no beat is lost or duplicated under any backpressure pattern.
REQ-026 flush_in with count > 0 and no beat accepted in that cycle closes the partial word as in REQ-021 only if the output register is free or draining that cycle; otherwise the request is held pending until it can close.
REQ-027 flush_in in the same cycle as an accepted beat: the beat is included, then the word closes.
REQ-028 flush_in with count == 0 and no accepted beat: no-op; no empty word is emitted.
REQ-029 A word that is full on its closing beat has chunk_tkeep all ones.
REQ-030 words_out increments by 1 per word acceptance; 0xFFFFFFFF wraps to 0.

Reset
REQ-031 While rst_in is high: chunk_tvalid = 0, chunk_tdata = 0, chunk_tkeep = 0, chunk_tlast = 0, count = 0, pending flush cleared, words_out = 0; pixel_tready = 1 the first cycle after release.
REQ-032 Reset mid-word or mid-stall discards partial and pending data; no word is emitted for it after release.

Verification
REQ-033 IN_W=8, RATIO=4, chunk_tready=1; beats 0x11,0x22,0x33,0x44 on consecutive clocks -> one cycle later chunk_tdata=0x44332211, tkeep=4'b1111, tlast=0, words_out=1.
REQ-034 FLUSH_ON_LAST=1; beats 0xAA,0xBB with tlast on 0xBB -> chunk_tdata=0x0000BBAA, tkeep=4'b0011, tlast=1; next beat starts lane 0.
REQ-035 chunk_tready=0 for 10 cycles after one full word, 12 beats offered -> 4 beats accepted, then pixel_tready=0; word 1 held stable; on release all 12 beats appear in order, no gaps or duplicates.
REQ-036 Three beats then flush_in with no beat -> tkeep=4'b0111, top lane zero; flush_in at count 0 -> no chunk_tvalid.
REQ-037 rst_in asserted after 2 beats and with a word stalled -> chunk_tvalid=0, words_out=0; next 4 beats form a clean word with no residue.
REQ-038 Random tvalid/tready over 10k beats at default parameters -> output concatenation equals input stream; tlast positions match.
